// File: rtl/tick_scheduler_pkg.sv
// Shared types and constants for the tick scheduler: run-control states,
// reset-time divisor/ratio and the clamp floors applied to new configurations.
package tick_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_STOPPING = 2'd2
    } state_t;

    localparam int DEF_DIV_M = 12500;
    localparam int DEF_RATIO = 4;
    localparam int MIN_DIV   = 2;
    localparam int MIN_RATIO = 1;

endpackage

// File: rtl/tick_divider.sv
// Loadable modulo counter with a combinational wrap flag; counts 0..modulus-1
// while enabled and reports wrap on the last count.
module tick_divider #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    input  logic [W-1:0] modulus,
    output logic [W-1:0] cnt,
    output logic         wrap
);

    assign wrap = en && (cnt == modulus - W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en) begin
            cnt <= wrap ? '0 : cnt + W'(1);
        end
    end

endmodule

// File: rtl/tick_scheduler.sv
// Run-control scheduler producing phase-aligned, registered symbol and level
// tick enables with glitch-free start/stop and level-boundary reconfiguration.
module tick_scheduler
    import tick_scheduler_pkg::*;
#(
    parameter int CNT_W     = 14,
    parameter int RAT_W     = 4,
    parameter int DEF_DIV_M = tick_scheduler_pkg::DEF_DIV_M,
    parameter int DEF_RATIO = tick_scheduler_pkg::DEF_RATIO
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_div_m,
    input  logic [RAT_W-1:0] cfg_ratio,
    output logic             tick_m,
    output logic             tick_level,
    output logic [RAT_W-1:0] m_idx,
    output logic             running,
    output logic             busy_cfg,
    output state_t           state_dbg,
    output logic [CNT_W-1:0] div_cnt_dbg
);

    state_t           state_q, state_d;
    logic             start_run;
    logic             is_idle;
    logic [CNT_W-1:0] div_act_q, div_shd_q, div_in;
    logic [RAT_W-1:0] rat_act_q, rat_shd_q, rat_in;
    logic             busy_q;
    logic             tick_m_q, tick_level_q;
    logic             cfg_fire;
    logic [CNT_W-1:0] sym_cnt;
    logic             sym_wrap;
    logic [RAT_W-1:0] rat_cnt;
    logic             rat_wrap;

    // Config handshake: a word transfers on a cycle where cfg_valid && cfg_ready;
    // cfg_ready is low while a shadowed word waits for the next level boundary.
    assign cfg_ready = !busy_q;
    assign cfg_fire  = cfg_valid && cfg_ready;
    assign is_idle   = (state_q == ST_IDLE);

    assign div_in = (cfg_div_m < CNT_W'(MIN_DIV))   ? CNT_W'(MIN_DIV)   : cfg_div_m;
    assign rat_in = (cfg_ratio < RAT_W'(MIN_RATIO)) ? RAT_W'(MIN_RATIO) : cfg_ratio;

    always_comb begin
        state_d   = state_q;
        start_run = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_RUN;
                    start_run = 1'b1;
                end
            end
            ST_RUN: begin
                if (stop) state_d = ST_RUN == ST_RUN ? ST_STOPPING : ST_RUN;
            end
            ST_STOPPING: begin
                if (start)             state_d = ST_RUN;
                else if (tick_level_q) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // The start cycle itself counts as symbol count 0, so the first wrap lands
    // div-1 cycles later and its registered tick appears div cycles after start.
    tick_divider #(.W(CNT_W)) u_sym_div (
        .clk      (clk),
        .rst      (rst),
        .load     (is_idle),
        .load_val (start_run ? CNT_W'(1) : CNT_W'(0)),
        .en       (!is_idle),
        .modulus  (div_act_q),
        .cnt      (sym_cnt),
        .wrap     (sym_wrap)
    );

    tick_divider #(.W(RAT_W)) u_rat_div (
        .clk      (clk),
        .rst      (rst),
        .load     (is_idle),
        .load_val (RAT_W'(0)),
        .en       (sym_wrap),
        .modulus  (rat_act_q),
        .cnt      (rat_cnt),
        .wrap     (rat_wrap)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_m_q     <= 1'b0;
            tick_level_q <= 1'b0;
        end else begin
            tick_m_q     <= sym_wrap;
            tick_level_q <= rat_wrap;
        end
    end

    // Shadowed words land while tick_level is visible: both counters sit at
    // zero then, so the new period begins cleanly on the following count.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_act_q <= CNT_W'(DEF_DIV_M);
            rat_act_q <= RAT_W'(DEF_RATIO);
            div_shd_q <= '0;
            rat_shd_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            if (cfg_fire && is_idle) begin
                div_act_q <= div_in;
                rat_act_q <= rat_in;
            end else if (cfg_fire) begin
                div_shd_q <= div_in;
                rat_shd_q <= rat_in;
                busy_q    <= 1'b1;
            end
            if (busy_q && tick_level_q) begin
                div_act_q <= div_shd_q;
                rat_act_q <= rat_shd_q;
                busy_q    <= 1'b0;
            end
        end
    end

    assign tick_m      = tick_m_q;
    assign tick_level  = tick_level_q;
    assign m_idx       = rat_cnt;
    assign running     = !is_idle;
    assign busy_cfg    = busy_q;
    assign state_dbg   = state_q;
    assign div_cnt_dbg = sym_cnt;

endmodule

// File: tb/tb_tick_scheduler.sv
// Scoreboard bench for tick_scheduler: expected ticks are queued when a run is
// launched and popped as the DUT emits tick_m.
module tb_tick_scheduler;
    import tick_scheduler_pkg::*;

    localparam int CNT_W = 14;
    localparam int RAT_W = 4;
    localparam int EW    = 37;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             stop;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [CNT_W-1:0] cfg_div_m;
    logic [RAT_W-1:0] cfg_ratio;
    logic             tick_m;
    logic             tick_level;
    logic [RAT_W-1:0] m_idx;
    logic             running;
    logic             busy_cfg;
    state_t           state_dbg;
    logic [CNT_W-1:0] div_cnt_dbg;

    tick_scheduler dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stop        (stop),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_div_m   (cfg_div_m),
        .cfg_ratio   (cfg_ratio),
        .tick_m      (tick_m),
        .tick_level  (tick_level),
        .m_idx       (m_idx),
        .running     (running),
        .busy_cfg    (busy_cfg),
        .state_dbg   (state_dbg),
        .div_cnt_dbg (div_cnt_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int t0       = 0;
    int n_checks = 0;
    int n_fail   = 0;

    logic [EW-1:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h (cycle %0d, rel %0d)",
                     tag, obs, exp, cyc, cyc - t0);
        end
    endtask

    // entry = {cycle relative to start, tick_level, m_idx}
    function automatic logic [EW-1:0] tick_ent(input int r, input bit lvl, input int idx);
        return {32'(r), lvl, 4'(idx)};
    endfunction

    task automatic push_run(input int div, input int ratio, input int k_first, input int k_last);
        for (int k = k_first; k <= k_last; k++) begin
            exp_q.push_back(tick_ent(k * div, (k % ratio) == 0, k % ratio));
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic to_cycle(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic at(input int r);
        to_cycle(t0 + r);
    endtask

    task automatic do_cfg(input int d, input int r);
        cfg_valid = 1'b1;
        cfg_div_m = 14'(d);
        cfg_ratio = 4'(r);
        to_cycle(cyc + 1);
        cfg_valid = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        t0    = cyc;
        to_cycle(cyc + 1);
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        to_cycle(cyc + 1);
        stop = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tick_m"},     tick_m,     1'b0);
        check({tag, "_tick_level"}, tick_level, 1'b0);
        check({tag, "_m_idx"},      m_idx,      4'd0);
        check({tag, "_running"},    running,    1'b0);
        check({tag, "_busy_cfg"},   busy_cfg,   1'b0);
        check({tag, "_cfg_ready"},  cfg_ready,  1'b1);
        check({tag, "_state"},      state_dbg,  ST_IDLE);
    endtask

    // ---------------- scoreboard monitor ----------------
    logic [EW-1:0] obs_v;
    logic [EW-1:0] exp_v;

    always @(negedge clk) begin
        if (tick_level) check("level_has_m", tick_m, 1'b1);
        if (tick_m) begin
            if (exp_q.size() == 0) begin
                check("stray_tick", tick_m, 1'b0);
            end else begin
                exp_v = exp_q.pop_front();
                obs_v = {32'(cyc - t0), tick_level, m_idx};
                check("tick", obs_v, exp_v);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        stop      = 1'b0;
        cfg_valid = 1'b0;
        cfg_div_m = '0;
        cfg_ratio = '0;
        to_cycle(3);
        rst = 1'b0;
        check_reset_outputs("reset");

        // basic run with div 5 / ratio 3, stop at 17 ends after level at 30
        do_cfg(5, 3);
        check("busy_after_idle_cfg", busy_cfg, 1'b0);
        to_cycle(cyc + 2);
        do_start();
        push_run(5, 3, 1, 6);
        at(17);
        pulse_stop();
        at(30);
        check("run1_running_30", running, 1'b1);
        at(31);
        check("run1_running_31", running, 1'b0);
        check("run1_state_31", state_dbg, ST_IDLE);
        at(45);
        check("run1_drain", exp_q.size(), 0);

        // reconfigure mid-run to div 4 / ratio 2 at cycle 7; a second offer stalls
        do_cfg(5, 3);
        do_start();
        push_run(5, 3, 1, 3);
        exp_q.push_back(tick_ent(19, 1'b0, 1));
        exp_q.push_back(tick_ent(23, 1'b1, 0));
        exp_q.push_back(tick_ent(27, 1'b0, 1));
        exp_q.push_back(tick_ent(31, 1'b1, 0));
        at(7);
        check("run2_ready_7", cfg_ready, 1'b1);
        cfg_valid = 1'b1;
        cfg_div_m = 14'd4;
        cfg_ratio = 4'd2;
        at(8);
        cfg_valid = 1'b0;
        check("run2_busy_8", busy_cfg, 1'b1);
        check("run2_ready_8", cfg_ready, 1'b0);
        at(10);
        cfg_valid = 1'b1;
        cfg_div_m = 14'd9;
        cfg_ratio = 4'd7;
        check("run2_ready_10", cfg_ready, 1'b0);
        at(12);
        cfg_valid = 1'b0;
        check("run2_busy_12", busy_cfg, 1'b1);
        at(17);
        check("run2_busy_17", busy_cfg, 1'b0);
        check("run2_ready_17", cfg_ready, 1'b1);
        at(24);
        pulse_stop();
        at(32);
        check("run2_running_32", running, 1'b0);
        at(40);
        check("run2_drain", exp_q.size(), 0);

        // zero divisor and ratio clamp to 2 and 1
        do_cfg(0, 0);
        do_start();
        for (int k = 1; k <= 3; k++) exp_q.push_back(tick_ent(2 * k, 1'b1, 0));
        at(5);
        pulse_stop();
        check("run3_running_6", running, 1'b1);
        at(7);
        check("run3_running_7", running, 1'b0);
        at(12);
        check("run3_drain", exp_q.size(), 0);

        // stop at 12 cancelled by start at 13: phase unchanged
        do_cfg(5, 3);
        do_start();
        push_run(5, 3, 1, 12);
        at(12);
        stop = 1'b1;
        at(13);
        stop = 1'b0;
        check("run4_state_13", state_dbg, ST_STOPPING);
        start = 1'b1;
        at(14);
        start = 1'b0;
        check("run4_state_14", state_dbg, ST_RUN);
        at(31);
        check("run4_running_31", running, 1'b1);
        at(46);
        pulse_stop();
        at(60);
        check("run4_running_60", running, 1'b1);
        at(61);
        check("run4_running_61", running, 1'b0);
        at(70);
        check("run4_drain", exp_q.size(), 0);

        // reset while a shadow config is pending restores defaults
        do_cfg(5, 3);
        do_start();
        push_run(5, 3, 1, 2);
        at(10);
        do_cfg(7, 2);
        check("run5_busy_11", busy_cfg, 1'b1);
        at(12);
        rst = 1'b1;
        at(13);
        rst = 1'b0;
        check_reset_outputs("midrst");
        check("run5_drain_rst", exp_q.size(), 0);
        to_cycle(cyc + 3);
        do_start();
        pulse_stop();
        push_run(12500, 4, 1, 4);
        at(50000);
        check("run5_running_50000", running, 1'b1);
        at(50001);
        check("run5_running_50001", running, 1'b0);
        at(50010);
        check("run5_drain", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
